// File: rtl/fft_mag_writer.sv
// -----------------------------------------------------------------------------
// fft_mag_writer
// Takes the streaming complex output of the FFT core, computes the squared
// magnitude of every bin and writes it into FFT_RAM. Once a whole frame is
// stored, fftdone is raised and the RAM is left untouched until freqdetect
// answers with detectdone.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   src_valid/sop/eop   FFT stream handshake and framing flags
//   src_real/src_imag   signed complex sample
//   src_ready           block accepts a sample this cycle
//   detectdone          one-cycle release pulse from freqdetect
//   wren/wraddr/data    RAM write port (bin index, saturated magnitude)
//   fftdone             level, a complete frame is held in RAM
//   err_frame           one-cycle pulse on a framing error
//
// Optional feature: define FMW_DC_NULL_EN to force the bin-0 (DC) word to zero
// so it can never win the peak search downstream. Write timing is unchanged.
// -----------------------------------------------------------------------------
module fft_mag_writer #(
    parameter int NPOINTS = 1024,
    parameter int AW      = 10,
    parameter int IW      = 16,
    parameter int MW      = 28,
    parameter int SHIFT   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 src_valid,
    input  logic                 src_sop,
    input  logic                 src_eop,
    input  logic signed [IW-1:0] src_real,
    input  logic signed [IW-1:0] src_imag,
    output logic                 src_ready,
    input  logic                 detectdone,
    output logic                 wren,
    output logic [AW-1:0]        wraddr,
    output logic [MW-1:0]        data,
    output logic                 fftdone,
    output logic                 err_frame
);

    // Width of re^2 + im^2; one extra bit so the sum never overflows.
    localparam int SW = 2 * IW + 1;
    localparam logic [AW-1:0] LAST_BIN = AW'(NPOINTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [AW-1:0]       bin_r;
    logic                drain_r;
    logic                accept_s;
    logic                take_s;
    logic                last_s;
    logic [AW-1:0]       sample_bin_s;
    logic signed [2*IW-1:0] re_prod_s;
    logic signed [2*IW-1:0] im_prod_s;
    logic                s1_valid_r;
    logic [AW-1:0]       s1_addr_r;
    logic [2*IW-1:0]     s1_re_sq_r;
    logic [2*IW-1:0]     s1_im_sq_r;
    logic [SW-1:0]       sum_s;
    logic [MW-1:0]       mag_s;

    // Clamp a shifted magnitude to the largest RAM word.
    function automatic logic [MW-1:0] sat_mag(input logic [SW-1:0] v);
        logic [SW+MW-1:0] wide;
        wide = {{MW{1'b0}}, v};
        if (wide > {{SW{1'b0}}, {MW{1'b1}}}) begin
            sat_mag = {MW{1'b1}};
        end else begin
            sat_mag = wide[MW-1:0];
        end
    endfunction

    // Full signed products: the most negative input squares exactly.
    assign re_prod_s = src_real * src_real;
    assign im_prod_s = src_imag * src_imag;

    // Decide whether the current accept enters the pipeline and which bin it is.
    always_comb begin
        accept_s     = src_valid & src_ready;
        take_s       = 1'b0;
        sample_bin_s = '0;
        case (state_r)
            IDLE: begin
                // Only a clean start-of-frame opens a frame; anything else is dropped.
                take_s       = accept_s & src_sop & ~src_eop;
                sample_bin_s = '0;
            end
            WRITE: begin
                take_s = accept_s;
                if (src_sop) begin
                    sample_bin_s = '0;
                end else begin
                    sample_bin_s = bin_r;
                end
            end
            default: begin
                take_s       = 1'b0;
                sample_bin_s = '0;
            end
        endcase
        last_s = (sample_bin_s == LAST_BIN);
    end

    // Frame control FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            bin_r     <= '0;
            drain_r   <= 1'b0;
            src_ready <= 1'b0;
            fftdone   <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            case (state_r)
                IDLE: begin
                    src_ready <= 1'b1;
                    fftdone   <= 1'b0;
                    if (accept_s && src_sop && src_eop) begin
                        err_frame <= 1'b1;
                    end else if (take_s) begin
                        bin_r   <= AW'(1);
                        state_r <= WRITE;
                    end
                end
                WRITE: begin
                    if (accept_s) begin
                        bin_r <= sample_bin_s + AW'(1);
                        if (last_s) begin
                            // Frame complete (missing eop is tolerated).
                            state_r   <= DRAIN;
                            drain_r   <= 1'b0;
                            src_ready <= 1'b0;
                            err_frame <= src_sop;
                        end else if (src_eop) begin
                            // Short frame: the bin is still written, no fftdone.
                            state_r   <= IDLE;
                            src_ready <= 1'b1;
                            err_frame <= 1'b1;
                        end else begin
                            src_ready <= 1'b1;
                            err_frame <= src_sop;
                        end
                    end else begin
                        src_ready <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Two cycles let the last bin leave the datapath.
                    src_ready <= 1'b0;
                    if (drain_r) begin
                        state_r <= DONE;
                        fftdone <= 1'b1;
                    end else begin
                        drain_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (detectdone) begin
                        state_r   <= IDLE;
                        fftdone   <= 1'b0;
                        src_ready <= 1'b1;
                    end else begin
                        fftdone   <= 1'b1;
                        src_ready <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    src_ready <= 1'b0;
                    fftdone   <= 1'b0;
                end
            endcase
        end
    end

    // Stage-2 arithmetic: sum, shift, saturate, optional DC null.
    always_comb begin
        sum_s = {1'b0, s1_re_sq_r} + {1'b0, s1_im_sq_r};
`ifdef FMW_DC_NULL_EN
        if (s1_addr_r == '0) begin
            mag_s = '0;
        end else begin
            mag_s = sat_mag(sum_s >> SHIFT);
        end
`else
        mag_s = sat_mag(sum_s >> SHIFT);
`endif
    end

    // Two-stage magnitude pipeline; reset flushes it so no stale write escapes.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_addr_r  <= '0;
            s1_re_sq_r <= '0;
            s1_im_sq_r <= '0;
            wren       <= 1'b0;
            wraddr     <= '0;
            data       <= '0;
        end else begin
            s1_valid_r <= take_s;
            if (take_s) begin
                s1_addr_r  <= sample_bin_s;
                s1_re_sq_r <= $unsigned(re_prod_s);
                s1_im_sq_r <= $unsigned(im_prod_s);
            end
            wren <= s1_valid_r;
            if (s1_valid_r) begin
                wraddr <= s1_addr_r;
                data   <= mag_s;
            end
        end
    end

endmodule

// File: tb/tb_fft_mag_writer.sv
module tb_fft_mag_writer;

    localparam int NP = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, src_valid, src_sop, src_eop, detectdone;
    logic signed [15:0] src_real, src_imag;
    logic src_ready_a, wren_a, fftdone_a, err_a;
    logic [9:0] wraddr_a;
    logic [27:0] data_a;
    logic src_ready_b, wren_b, fftdone_b, err_b;
    logic [9:0] wraddr_b;
    logic [27:0] data_b;

    // Default configuration (SHIFT=5).
    fft_mag_writer dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_sop(src_sop),
        .src_eop(src_eop), .src_real(src_real), .src_imag(src_imag),
        .src_ready(src_ready_a), .detectdone(detectdone), .wren(wren_a),
        .wraddr(wraddr_a), .data(data_a), .fftdone(fftdone_a), .err_frame(err_a)
    );

    // SHIFT=0 instance exposes saturation; it sees the same stream.
    fft_mag_writer #(.SHIFT(0)) dut_sat (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_sop(src_sop),
        .src_eop(src_eop), .src_real(src_real), .src_imag(src_imag),
        .src_ready(src_ready_b), .detectdone(detectdone), .wren(wren_b),
        .wraddr(wraddr_b), .data(data_b), .fftdone(fftdone_b), .err_frame(err_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int wcount = 0;
    int errcnt = 0;
    logic [27:0] ram_a [0:NP-1];
    logic [27:0] ram_b [0:NP-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Magnitude as stated: (re^2+im^2)>>sh clamped to 28 bits, DC null optional.
    function automatic logic [63:0] exp_mag(input int re, input int im, input int sh, input int addr);
        longint s, mx;
        s  = (longint'(re) * longint'(re) + longint'(im) * longint'(im)) >> sh;
        mx = (longint'(1) << 28) - longint'(1);
`ifdef FMW_DC_NULL_EN
        if (addr == 0) return 64'd0;
`endif
        if (s > mx) return mx;
        return s;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct { int due; int addr; int re; int im; } wr_t;
    wr_t q[$];
    int  m_mode = 0;   // 0 idle, 1 frame open, 2 draining, 3 frame held
    int  m_bin = 0;
    int  m_dcnt = 0;
    bit  m_ready = 0, m_fft = 0, m_err = 0, m_live = 0, m_clean = 1;

    always @(negedge clk) begin
        wr_t h;
        bit  acc;
        int  b;
        if (m_live) begin
            chk("src_ready", src_ready_a, m_ready);
            chk("src_ready_sat", src_ready_b, m_ready);
            chk("fftdone", fftdone_a, m_fft);
            chk("fftdone_sat", fftdone_b, m_fft);
            chk("err_frame", err_a, m_err);
            if (q.size() > 0 && q[0].due == cyc) begin
                h = q.pop_front();
                m_clean = 0;
                chk("wren", wren_a, 1);
                chk("wren_sat", wren_b, 1);
                chk("wraddr", wraddr_a, h.addr);
                chk("data", data_a, exp_mag(h.re, h.im, 5, h.addr));
                chk("data_sat", data_b, exp_mag(h.re, h.im, 0, h.addr));
            end else begin
                chk("wren", wren_a, 0);
                chk("wren_sat", wren_b, 0);
                if (m_clean) begin
                    chk("wraddr_rst", wraddr_a, 0);
                    chk("data_rst", data_a, 0);
                end
            end
        end
        if (reset) begin
            m_mode = 0; m_ready = 0; m_fft = 0; m_err = 0;
            m_clean = 1; m_live = 1;
            q.delete();
        end else if (m_live) begin
            acc   = src_valid && m_ready;
            m_err = 0;
            if (m_mode == 0) begin
                if (acc && src_sop && src_eop) m_err = 1;
                else if (acc && src_sop) begin
                    q.push_back('{cyc + 2, 0, int'(src_real), int'(src_imag)});
                    m_bin = 1; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (acc) begin
                    b = src_sop ? 0 : m_bin;
                    q.push_back('{cyc + 2, b, int'(src_real), int'(src_imag)});
                    m_err = src_sop;
                    if (b == NP - 1) begin
                        m_mode = 2; m_dcnt = 2;
                    end else begin
                        if (src_eop) begin m_err = 1; m_mode = 0; end
                        m_bin = b + 1;
                    end
                end
            end else if (m_mode == 2) begin
                m_dcnt--;
                if (m_dcnt == 0) m_mode = 3;
            end else begin
                if (detectdone) m_mode = 0;
            end
            m_ready = (m_mode <= 1);
            m_fft   = (m_mode == 3);
        end
    end

    // RAM image and error pulse tally used by the literal checks.
    always @(negedge clk) begin
        if (wren_a === 1'b1) begin ram_a[wraddr_a] = data_a; wcount++; end
        if (wren_b === 1'b1) ram_b[wraddr_b] = data_b;
        if (err_a === 1'b1) errcnt++;
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit sop, input bit eop, input logic signed [15:0] re,
                        input logic signed [15:0] im);
        int waited;
        bit done;
        src_valid = 1'b1; src_sop = sop; src_eop = eop; src_real = re; src_imag = im;
        waited = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            if (src_ready_a === 1'b1) begin
                last_acc = cyc; done = 1;
            end else begin
                waited++;
                if (waited > 50) begin
                    checks++; errors++;
                    $display("FAIL send_timeout: src_ready is %b, required 1", src_ready_a);
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
    endtask

    task automatic wait_done();
        int at, n;
        at = -1; n = 0;
        while (at < 0 && n < 20) begin
            @(negedge clk);
            if (fftdone_a === 1'b1) at = cyc;
            n++;
        end
        chk("fftdone_latency", at - last_acc, 3);
    endtask

    task automatic release_frame();
        @(posedge clk); #1 detectdone = 1'b1;
        @(posedge clk); #1 detectdone = 1'b0;
    endtask

    initial begin
        logic [27:0] e0a, e0b, e1a, e1b;
`ifdef FMW_DC_NULL_EN
        e0a = 28'd0; e0b = 28'd0; e1a = 28'd0; e1b = 28'd0;
`else
        e0a = 28'd8; e0b = 28'd256; e1a = 28'h1FFF800; e1b = 28'hFFFFFFF;
`endif
        reset = 1'b1; detectdone = 1'b0;
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0; src_real = '0; src_imag = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Full frame, tone at bin 204.
        wcount = 0;
        for (int i = 0; i < NP; i++)
            send(i == 0, i == NP - 1, (i == 204) ? 16'sh0100 : 16'sh0010, 16'sh0000);
        idle();
        wait_done();
        @(posedge clk); #1;
        chk("t1_bin204", ram_a[204], 28'd2048);
        chk("t1_bin5", ram_a[5], 28'd8);
        chk("t1_bin0", ram_a[0], e0a);
        chk("t1_bin0_sat", ram_b[0], e0b);
        chk("t1_bin1023", ram_a[1023], 28'd8);
        chk("t1_sat_bin204", ram_b[204], 28'd65536);
        chk("t1_writes", wcount, 1024);

        // Next frame presented while the first is held: must stall.
        src_valid = 1'b1; src_sop = 1'b1; src_eop = 1'b0;
        src_real = 16'sh7FFF; src_imag = 16'sh0000;
        repeat (3) begin
            @(negedge clk);
            chk("hold_ready", src_ready_a, 0);
            chk("hold_wren", wren_a, 0);
        end
        release_frame();
        wcount = 0;
        for (int i = 0; i < NP; i++) begin
            if (i == 0) send(1'b1, 1'b0, 16'sh7FFF, 16'sh0000);
            else if (i == 1) send(1'b0, 1'b0, -16'sd32768, -16'sd32768);
            else send(1'b0, i == NP - 1, 16'(i), -16'(i));
        end
        idle();
        wait_done();
        @(posedge clk); #1;
        chk("t6_bin0", ram_a[0], e1a);
        chk("t6_bin0_sat", ram_b[0], e1b);
        chk("t2_min_sq", ram_a[1], 28'h4000000);
        chk("t2_saturate", ram_b[1], 28'hFFFFFFF);
        chk("t2_bin100", ram_a[100], 28'd625);
        chk("t2_bin100_sat", ram_b[100], 28'd20000);
        chk("t2_bin1023", ram_a[1023], 28'd65408);
        chk("t3_writes", wcount, 1024);
        release_frame();

        // Early eop at bin 99.
        wcount = 0; errcnt = 0;
        for (int i = 0; i < 100; i++) send(i == 0, i == 99, 16'(i), 16'sd5);
        idle();
        repeat (5) @(posedge clk);
        #1;
        chk("t4_errs", errcnt, 1);
        chk("t4_writes", wcount, 100);
        chk("t4_bin99", ram_a[99], 28'd307);
        chk("t4_fftdone", fftdone_a, 0);
        chk("t4_ready", src_ready_a, 1);

        // Stray sample and sop+eop in IDLE: both dropped, only the latter flagged.
        wcount = 0; errcnt = 0;
        send(1'b0, 1'b0, 16'sd100, 16'sd0);
        send(1'b1, 1'b1, 16'sd100, 16'sd0);
        idle();
        repeat (4) @(posedge clk);
        #1;
        chk("idle_drop_errs", errcnt, 1);
        chk("idle_drop_writes", wcount, 0);

        // Frame restarted by sop at step 21, detectdone mid-frame, reset at bin 500.
        for (int k = 0; k < 521; k++) begin
            detectdone = (k == 50);
            send(k == 0 || k == 21, 1'b0, 16'(k * 3), 16'sd7);
        end
        detectdone = 1'b0;
        src_valid = 1'b1; src_sop = 1'b0; src_real = 16'sd1500; src_imag = 16'sd7;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        idle();
        @(negedge clk);
        chk("t5_wren", wren_a, 0);
        chk("t5_wraddr", wraddr_a, 0);
        chk("t5_data", data_a, 0);
        chk("t5_ready", src_ready_a, 0);
        chk("t5_fftdone", fftdone_a, 0);
        chk("t5_err", err_a, 0);
        @(posedge clk); #1;

        // Fresh frame after reset completes normally.
        for (int i = 0; i < NP; i++)
            send(i == 0, i == NP - 1, 16'(i * 29 - 5000), 16'(3000 - i * 11));
        idle();
        wait_done();
        release_frame();
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

endmodule
